cpu16_top: RTL and testbench

Top level of a 16-bit, 4-register, multi-cycle accumulator-style CPU with on-chip instruction ROM and data RAM. It fetches one 16-bit instruction per 5-cycle sequence, executes it, and writes results back to a 4×16 register file. The block has no functional output ports; it is observed through its internal hierarchy.

---
 rtl/cpu16_top.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_cpu16_top.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu16_top.sv
// -----------------------------------------------------------------------------
// cpu16_top -- 16-bit, 4-register, multi-cycle accumulator-style CPU with an
// on-chip synchronous instruction ROM and a 256-word data RAM.
//
// Every instruction takes five enabled cycles: FETCH, DECODE, EXEC, WB, PCUP.
//
// Ports (top):
//   clk    in  1  single clock, rising-edge
//   rst    in  1  synchronous, active-high reset (state, PC, IR, registers)
//   en_in  in  1  run enable; low freezes FSM, PC, registers and memories
//
// Optional feature macro: CPU_DMEM_PRELOAD_EN
//   defined     -> data RAM powers up with word 101 = 16'd50, all others 0
//   not defined -> data RAM powers up all zero
//
// Modules in this file: cpu16_pkg, sync_rom, irom, data_ram, register16,
// reg_group, data_path, cpu, cpu16_top.
// -----------------------------------------------------------------------------

package cpu16_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_PCUP   = 3'd4
  } state_t;

  localparam logic [3:0] OP_MOVI = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUBI = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_ORI  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_LDRI = 4'hA;
  localparam logic [3:0] OP_STR  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
endpackage

// -----------------------------------------------------------------------------
// sync_rom -- synchronous-read ROM array. Contents are loaded externally.
//   clk in, en in (read enable), addr in [AWIDTH], data_q out [DWIDTH]
// -----------------------------------------------------------------------------
module sync_rom #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] data_q
);
  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clk) begin
    if (en) data_q <= mem[addr];
  end
endmodule

// -----------------------------------------------------------------------------
// irom -- instruction ROM wrapper.
//   clk in, en in, addr in [AWIDTH], data out [DWIDTH]
// -----------------------------------------------------------------------------
module irom #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] data
);
  sync_rom #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) sync_rom_i (
    .clk    (clk),
    .en     (en),
    .addr   (addr),
    .data_q (data)
  );
endmodule

// -----------------------------------------------------------------------------
// data_ram -- single-port data RAM, synchronous write and synchronous read.
//   clk in, we in, re in, addr in [AW], wdata in [DWIDTH], rdata_q out [DWIDTH]
// -----------------------------------------------------------------------------
module data_ram #(
  parameter int DWIDTH = 16,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata_q
);
`ifdef CPU_DMEM_PRELOAD_EN
  localparam logic PRELOAD = 1'b1;
`else
  localparam logic PRELOAD = 1'b0;
`endif

  logic [DWIDTH-1:0] mem [0:(1<<AW)-1];

  // Power-up image of the RAM.
  function automatic logic [DWIDTH-1:0] init_word(input logic [AW-1:0] a);
    init_word = (PRELOAD && (a == AW'(101))) ? DWIDTH'(50) : '0;
  endfunction

  // Words are stored XORed with their power-up image, so an all-zero array
  // reads back as the image with no init sequencer and no reset dependence.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata ^ init_word(addr);
    if (re) rdata_q   <= mem[addr] ^ init_word(addr);
  end
endmodule

// -----------------------------------------------------------------------------
// register16 -- one register with synchronous reset and write enable.
//   clk in, rst in, we in, d in [DWIDTH], q out [DWIDTH]
// -----------------------------------------------------------------------------
module register16 #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DWIDTH-1:0] d,
  output logic [DWIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

// -----------------------------------------------------------------------------
// reg_group -- 4 x DWIDTH register file storage, one write port.
//   clk in, rst in, we in, waddr in [2], wdata in [DWIDTH],
//   q0..q3 out [DWIDTH] (current register contents)
// -----------------------------------------------------------------------------
module reg_group #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] q0,
  output logic [DWIDTH-1:0] q1,
  output logic [DWIDTH-1:0] q2,
  output logic [DWIDTH-1:0] q3
);
  logic [3:0] we_vec;

  always_comb begin
    we_vec        = 4'b0000;
    we_vec[waddr] = we;
  end

  register16 #(.DWIDTH(DWIDTH)) x0 (.clk(clk), .rst(rst), .we(we_vec[0]), .d(wdata), .q(q0));
  register16 #(.DWIDTH(DWIDTH)) x1 (.clk(clk), .rst(rst), .we(we_vec[1]), .d(wdata), .q(q1));
  register16 #(.DWIDTH(DWIDTH)) x2 (.clk(clk), .rst(rst), .we(we_vec[2]), .d(wdata), .q(q2));
  register16 #(.DWIDTH(DWIDTH)) x3 (.clk(clk), .rst(rst), .we(we_vec[3]), .d(wdata), .q(q3));
endmodule

// -----------------------------------------------------------------------------
// data_path -- register file read ports, ALU with result register, write-back
// mux and data-RAM address/data generation.
//   clk, rst in; alu_en in (EXEC), reg_we in (WB), wb_sel_ram in (LDRI);
//   ir in [DWIDTH]; ram_rdata in [DWIDTH];
//   ram_addr out [DMEM_AWIDTH]; ram_wdata out [DWIDTH]
// -----------------------------------------------------------------------------
module data_path #(
  parameter int DWIDTH      = 16,
  parameter int DMEM_AWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_en,
  input  logic                   reg_we,
  input  logic                   wb_sel_ram,
  input  logic [DWIDTH-1:0]      ir,
  input  logic [DWIDTH-1:0]      ram_rdata,
  output logic [DMEM_AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0]      ram_wdata
);
  import cpu16_pkg::*;

  logic [3:0]        op;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [7:0]        imm8;
  logic [DWIDTH-1:0] imm16;
  logic [DWIDTH-1:0] q0, q1, q2, q3;
  logic [DWIDTH-1:0] rd_val;
  logic [DWIDTH-1:0] rs_val;
  logic [DWIDTH-1:0] alu_d;
  logic [DWIDTH-1:0] alu_q;
  logic [DWIDTH-1:0] wb_data;
  logic [7:0]        str_addr;

  assign op    = ir[15:12];
  assign rd    = ir[11:10];
  assign rs    = ir[9:8];
  assign imm8  = ir[7:0];
  assign imm16 = DWIDTH'(imm8);

  reg_group #(.DWIDTH(DWIDTH)) reg_group_i (
    .clk   (clk),
    .rst   (rst),
    .we    (reg_we),
    .waddr (rd),
    .wdata (wb_data),
    .q0    (q0),
    .q1    (q1),
    .q2    (q2),
    .q3    (q3)
  );

  // Two asynchronous read ports; a write in the same cycle is seen next cycle.
  always_comb begin
    rd_val = q0;
    case (rd)
      2'd1:    rd_val = q1;
      2'd2:    rd_val = q2;
      2'd3:    rd_val = q3;
      default: rd_val = q0;
    endcase
    rs_val = q0;
    case (rs)
      2'd1:    rs_val = q1;
      2'd2:    rs_val = q2;
      2'd3:    rs_val = q3;
      default: rs_val = q0;
    endcase
  end

  always_comb begin
    alu_d = rd_val;
    case (op)
      OP_MOVI: alu_d = imm16;
      OP_MOV:  alu_d = rs_val;
      OP_ADDI: alu_d = rd_val + imm16;
      OP_ADD:  alu_d = rd_val + rs_val;
      OP_SUBI: alu_d = rd_val - imm16;
      OP_SUB:  alu_d = rd_val - rs_val;
      OP_ANDI: alu_d = rd_val & imm16;
      OP_AND:  alu_d = rd_val & rs_val;
      OP_ORI:  alu_d = rd_val | imm16;
      OP_OR:   alu_d = rd_val | rs_val;
      default: alu_d = rd_val;
    endcase
  end

  // EXEC -> WB boundary: ALU result register.
  always_ff @(posedge clk) begin
    if (alu_en) alu_q <= alu_d;
  end

  // Only the low byte of rd + imm addresses the RAM, so an 8-bit add suffices.
  assign str_addr  = rd_val[7:0] + imm8;
  assign ram_addr  = (op == OP_STR) ? DMEM_AWIDTH'(str_addr) : DMEM_AWIDTH'(imm8);
  assign ram_wdata = rs_val;
  assign wb_data   = wb_sel_ram ? ram_rdata : alu_q;
endmodule

// -----------------------------------------------------------------------------
// cpu -- sequencing FSM, PC and instruction register, plus the data path.
//   clk, rst, en_in in; rom_data in [DWIDTH]; rom_en out; rom_addr out [AWIDTH];
//   ram_we, ram_re out; ram_addr out [DMEM_AWIDTH]; ram_wdata out [DWIDTH];
//   ram_rdata in [DWIDTH]
// -----------------------------------------------------------------------------
module cpu #(
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 12,
  parameter int DMEM_AWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_in,
  input  logic [DWIDTH-1:0]      rom_data,
  output logic                   rom_en,
  output logic [AWIDTH-1:0]      rom_addr,
  output logic                   ram_we,
  output logic                   ram_re,
  output logic [DMEM_AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0]      ram_wdata,
  input  logic [DWIDTH-1:0]      ram_rdata
);
  import cpu16_pkg::*;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [3:0]        op;
  logic              writes_rd;
  logic              alu_en;
  logic              reg_we;
  logic              wb_sel_ram;

  assign op        = ir_q[15:12];
  // Opcodes MOVI..LDRI write rd; STR, JMP and the NOP codes do not.
  assign writes_rd = (op <= OP_LDRI);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (en_in) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          state_d = S_EXEC;
          ir_d    = rom_data;
        end
        S_EXEC:   state_d = S_WB;
        S_WB:     state_d = S_PCUP;
        S_PCUP: begin
          state_d = S_FETCH;
          pc_d    = (op == OP_JMP) ? AWIDTH'(ir_q[7:0]) : pc_q + AWIDTH'(1);
        end
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Strobes are qualified with en_in so a frozen CPU leaves memories untouched.
  assign rom_en     = en_in && (state_q == S_FETCH);
  assign rom_addr   = pc_q;
  assign alu_en     = en_in && (state_q == S_EXEC);
  assign ram_re     = en_in && (state_q == S_EXEC) && (op == OP_LDRI);
  assign ram_we     = en_in && (state_q == S_EXEC) && (op == OP_STR);
  assign reg_we     = en_in && (state_q == S_WB) && writes_rd;
  assign wb_sel_ram = (op == OP_LDRI);

  data_path #(.DWIDTH(DWIDTH), .DMEM_AWIDTH(DMEM_AWIDTH)) data_path_i (
    .clk        (clk),
    .rst        (rst),
    .alu_en     (alu_en),
    .reg_we     (reg_we),
    .wb_sel_ram (wb_sel_ram),
    .ir         (ir_q),
    .ram_rdata  (ram_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata)
  );
endmodule

// -----------------------------------------------------------------------------
// cpu16_top -- CPU core, instruction ROM and data RAM.
// -----------------------------------------------------------------------------
module cpu16_top #(
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 12,
  parameter int DMEM_AWIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en_in
);
  logic                   rom_en;
  logic [AWIDTH-1:0]      rom_addr;
  logic [DWIDTH-1:0]      rom_data;
  logic                   ram_we;
  logic                   ram_re;
  logic [DMEM_AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0]      ram_wdata;
  logic [DWIDTH-1:0]      ram_rdata;

  irom #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) irom_i (
    .clk  (clk),
    .en   (rom_en),
    .addr (rom_addr),
    .data (rom_data)
  );

  data_ram #(.DWIDTH(DWIDTH), .AW(DMEM_AWIDTH)) dmem_i (
    .clk     (clk),
    .we      (ram_we),
    .re      (ram_re),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata_q (ram_rdata)
  );

  cpu #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DMEM_AWIDTH(DMEM_AWIDTH)) cpu_i (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en_in),
    .rom_data  (rom_data),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );
endmodule

// File: tb/tb_cpu16_top.sv
// -----------------------------------------------------------------------------
// tb_cpu16_top -- scoreboard bench for cpu16_top. The stimulus process loads
// the instruction ROM and queues the hand-computed register/PC snapshot each
// retired instruction must show; the monitor pops one entry whenever the CPU
// enters PCUP (write-back just completed) and compares.
// -----------------------------------------------------------------------------
module tb_cpu16_top;
  import cpu16_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic en_in = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] r3;
  } snap_t;

  snap_t exp_q[$];
  bit    prev_pcup = 1'b0;

`ifdef CPU_DMEM_PRELOAD_EN
  localparam logic [15:0] P = 16'd50;
`else
  localparam logic [15:0] P = 16'd0;
`endif

  cpu16_top dut (
    .clk   (clk),
    .rst   (rst),
    .en_in (en_in)
  );

  always #5 clk = ~clk;

  function automatic snap_t cur_snap();
    snap_t s;
    s.pc = dut.cpu_i.pc_q;
    s.r0 = dut.cpu_i.data_path_i.reg_group_i.x0.q;
    s.r1 = dut.cpu_i.data_path_i.reg_group_i.x1.q;
    s.r2 = dut.cpu_i.data_path_i.reg_group_i.x2.q;
    s.r3 = dut.cpu_i.data_path_i.reg_group_i.x3.q;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [11:0] pc, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
    snap_t s;
    s = '{pc: pc, r0: a, r1: b, r2: c, r3: d};
    exp_q.push_back(s);
  endtask

  task automatic check_regs(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    snap_t s;
    s = cur_snap();
    check({name, "_x0"}, 32'(s.r0), 32'(a));
    check({name, "_x1"}, 32'(s.r1), 32'(b));
    check({name, "_x2"}, 32'(s.r2), 32'(c));
    check({name, "_x3"}, 32'(s.r3), 32'(d));
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d retirements still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_pc_state(input string name, input logic [11:0] pc, input state_t st,
                               input int budget);
    int n;
    n = 0;
    while (n < budget && !(dut.cpu_i.pc_q == pc && dut.cpu_i.state_q == st)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(dut.cpu_i.pc_q == pc && dut.cpu_i.state_q == st)) begin
      errors++;
      $display("FAIL %s: timeout, pc=%0d state=%0d, expected pc=%0d state=%0d",
               name, dut.cpu_i.pc_q, dut.cpu_i.state_q, pc, st);
    end
  endtask

  // Monitor: one comparison per retired instruction.
  initial begin : monitor
    snap_t got;
    snap_t exp;
    forever begin
      @(negedge clk);
      if (dut.cpu_i.state_q == S_PCUP && !prev_pcup && exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        got = cur_snap();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL retire: got pc=%0d x0..x3=%h %h %h %h, expected pc=%0d x0..x3=%h %h %h %h",
                   got.pc, got.r0, got.r1, got.r2, got.r3,
                   exp.pc, exp.r0, exp.r1, exp.r2, exp.r3);
        end
      end
      prev_pcup = (dut.cpu_i.state_q == S_PCUP);
    end
  end

  initial begin : stimulus
    logic [15:0] prog [0:32];
    prog = '{16'h0001, 16'h0403, 16'h1800, 16'h3800, 16'h2C06, 16'h5E00, 16'h4001,
             16'h6C0C, 16'h7600, 16'hC014,
             16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF,
             16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF,
             16'h000A, 16'h9B00, 16'h807F, 16'hA465, 16'hB100, 16'hA87F,
             16'h4C05, 16'h2C01, 16'h0CF0, 16'hBC20, 16'hA410,
             16'h2005, 16'hC020};
    for (int i = 0; i < 4096; i++) dut.irom_i.sync_rom_i.mem[i] = 16'h0000;
    for (int i = 0; i < 33; i++) dut.irom_i.sync_rom_i.mem[i] = prog[i];

    repeat (3) @(negedge clk);
    check("rst0_pc", 32'(dut.cpu_i.pc_q), 32'd0);
    check("rst0_state", 32'(dut.cpu_i.state_q), 32'(S_FETCH));
    check("rst0_ir", 32'(dut.cpu_i.ir_q), 32'd0);
    check_regs("rst0", 16'd0, 16'd0, 16'd0, 16'd0);

    push(12'd0,  16'd1,   16'd0,   16'd0, 16'd0);
    push(12'd1,  16'd1,   16'd3,   16'd0, 16'd0);
    push(12'd2,  16'd1,   16'd3,   16'd1, 16'd0);
    push(12'd3,  16'd1,   16'd3,   16'd2, 16'd0);
    push(12'd4,  16'd1,   16'd3,   16'd2, 16'd6);
    push(12'd5,  16'd1,   16'd3,   16'd2, 16'd4);
    push(12'd6,  16'd0,   16'd3,   16'd2, 16'd4);
    push(12'd7,  16'd0,   16'd3,   16'd2, 16'd4);
    push(12'd8,  16'd0,   16'd2,   16'd2, 16'd4);
    push(12'd9,  16'd0,   16'd2,   16'd2, 16'd4);
    push(12'd20, 16'd10,  16'd2,   16'd2, 16'd4);
    push(12'd21, 16'd10,  16'd2,   16'd6, 16'd4);
    push(12'd22, 16'd127, 16'd2,   16'd6, 16'd4);
    push(12'd23, 16'd127, P,       16'd6, 16'd4);
    push(12'd24, 16'd127, P,       16'd6, 16'd4);
    push(12'd25, 16'd127, P,       P,     16'd4);
    push(12'd26, 16'd127, P,       P,     16'hFFFF);
    push(12'd27, 16'd127, P,       P,     16'd0);
    push(12'd28, 16'd127, P,       P,     16'h00F0);
    push(12'd29, 16'd127, P,       P,     16'h00F0);
    push(12'd30, 16'd127, 16'd127, P,     16'h00F0);

    rst = 1'b0;
    wait_drain("run1_drain", 1000);

    // Reset in the middle of ADDI X0,5 at address 31.
    wait_pc_state("wait_exec31", 12'd31, S_EXEC, 100);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst1_pc", 32'(dut.cpu_i.pc_q), 32'd0);
    check("rst1_state", 32'(dut.cpu_i.state_q), 32'(S_FETCH));
    check("rst1_ir", 32'(dut.cpu_i.ir_q), 32'd0);
    check_regs("rst1", 16'd0, 16'd0, 16'd0, 16'd0);

    // Second run: park on a self-jump at address 5.
    dut.irom_i.sync_rom_i.mem[5] = 16'hC005;
    push(12'd0, 16'd1, 16'd0, 16'd0, 16'd0);
    push(12'd1, 16'd1, 16'd3, 16'd0, 16'd0);
    push(12'd2, 16'd1, 16'd3, 16'd1, 16'd0);
    push(12'd3, 16'd1, 16'd3, 16'd2, 16'd0);
    push(12'd4, 16'd1, 16'd3, 16'd2, 16'd6);
    push(12'd5, 16'd1, 16'd3, 16'd2, 16'd6);
    push(12'd5, 16'd1, 16'd3, 16'd2, 16'd6);
    rst = 1'b0;

    // Freeze in EXEC of ADD X2,X0 for 20 cycles.
    wait_pc_state("wait_exec3", 12'd3, S_EXEC, 100);
    en_in = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_pc", 32'(dut.cpu_i.pc_q), 32'd3);
    check("hold_state", 32'(dut.cpu_i.state_q), 32'(S_EXEC));
    check_regs("hold", 16'd1, 16'd3, 16'd1, 16'd0);
    en_in = 1'b1;
    wait_drain("run2_drain", 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
